// File: rtl/ew_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ew_pkg
//  Brief    : Q-format constants, lane types and saturation helper shared by
//             the element-wise state-update tile.
//  Revision : 1.0 - initial release
// ============================================================================
package ew_pkg;

   // Fixed-point formats: lam is unsigned Q0.16, xt and s are signed Q8.8
   localparam int LAM_FRAC   = 16;
   localparam int S_FRAC     = 8;
   localparam int ONE_Q016   = 65536;
   localparam int ROUND_HALF = 32768;

   typedef logic        [15:0] lam_t;
   typedef logic signed [15:0] s_t;

   // Clamp a wide signed result into the signed 16-bit lane range
   function automatic s_t sat16(input logic signed [34:0] a);
      if (a > 35'sd32767)
         return 16'sh7fff;
      else if (a < -35'sd32768)
         return 16'sh8000;
      else
         return a[15:0];
   endfunction

endpackage : ew_pkg
`default_nettype wire

// File: rtl/ew_state_ram.sv
`default_nettype none
// ============================================================================
//  Module   : ew_state_ram
//  Brief    : Simple dual-port state RAM, synchronous read (old data on a
//             same-address write), synchronous write, plus a per-address
//             "initialised" bit vector with a bulk clear.
//  Revision : 1.0 - initial release
// ============================================================================
module ew_state_ram #(
   parameter int ADDR_W = 6,
   parameter int WIDTH  = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data,
   output logic              rd_init,
   input  logic              wr_en,
   input  logic              wr_set_init,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rd_data;
   logic [DEPTH-1:0] r_init;
   logic             r_rd_init;

   // Data array: write and registered read; the read sees pre-write contents
   always_ff @(posedge clk) begin
      if (wr_en)
         r_mem[wr_addr] <= wr_data;
      if (rd_en)
         r_rd_data <= r_mem[rd_addr];
   end

   // Init flags: clear wins over a concurrent set; a read during clear sees 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_init    <= '0;
         r_rd_init <= 1'b0;
      end else begin
         if (clr)
            r_init <= '0;
         else if (wr_en && wr_set_init)
            r_init[wr_addr] <= 1'b1;
         if (rd_en)
            r_rd_init <= r_init[rd_addr] & ~clr;
      end
   end

   assign rd_data = r_rd_data;
   assign rd_init = r_rd_init;

endmodule : ew_state_ram
`default_nettype wire

// File: rtl/ew_state_update_tile.sv
`default_nettype none
// ============================================================================
//  Module   : ew_state_update_tile
//  Brief    : Two-stage element-wise recurrent update
//             s_new = lam*s_prev + (1-lam)*xt per lane, state kept in an
//             internal RAM addressed by a per-timestep tile counter.
//             Optional macro EW_STALL_CNT_EN adds the stall_cnt output.
//  Revision : 1.0 - initial release
// ============================================================================
module ew_state_update_tile
   import ew_pkg::*;
#(
   parameter int TILE_SIZE  = 4,
   parameter int DATA_WIDTH = 16,
   parameter int D          = 256,
   parameter int S_ADDR_W   = 6
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             clr,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [TILE_SIZE*DATA_WIDTH-1:0]  in_lam_vec,
   input  logic [TILE_SIZE*DATA_WIDTH-1:0]  in_xt_vec,
   output logic                             s_out_valid,
   input  logic                             s_out_ready,
   output logic [TILE_SIZE*DATA_WIDTH-1:0]  s_out_vec,
   output logic                             s_out_last
`ifdef EW_STALL_CNT_EN
   ,
   output logic [31:0]                      stall_cnt
`endif
);

   localparam int N_TILES = D / TILE_SIZE;
   localparam int VEC_W   = TILE_SIZE * DATA_WIDTH;
   // Product of Q8.8 and Q0.16 carries LAM_FRAC+S_FRAC fraction bits
   localparam int SHIFT   = (LAM_FRAC + S_FRAC) - S_FRAC;
   localparam logic [S_ADDR_W-1:0] LAST_ADDR = S_ADDR_W'(N_TILES - 1);

   // Address spacing of at least 4 tiles rules out read-after-write hazards
   generate
      if (N_TILES < 4 || (1 << S_ADDR_W) < N_TILES || DATA_WIDTH != 16) begin : g_cfg_bad
         $error("ew_state_update_tile: illegal D/TILE_SIZE/S_ADDR_W/DATA_WIDTH");
      end
   endgenerate

   logic                w_in_fire;
   logic                w_s2_free;
   logic                w_s1_adv;
   logic [S_ADDR_W-1:0] r_addr;
   logic [S_ADDR_W-1:0] w_addr_cur;

   logic                r_s1_valid;
   logic                r_s1_stale;
   logic [VEC_W-1:0]    r_s1_lam;
   logic [VEC_W-1:0]    r_s1_xt;
   logic [S_ADDR_W-1:0] r_s1_addr;
   logic [VEC_W-1:0]    w_ram_rd_data;
   logic                w_ram_rd_init;
   logic [VEC_W-1:0]    w_s_new;

   logic                r_s2_valid;
   logic                r_s2_last;
   logic [VEC_W-1:0]    r_s2_vec;

   assign w_s2_free  = !r_s2_valid || s_out_ready;
   assign w_s1_adv   = r_s1_valid && w_s2_free;
   assign in_ready   = !r_s1_valid || w_s2_free;
   assign w_in_fire  = in_valid && in_ready;
   // A tile accepted together with clr restarts the sequence at address 0
   assign w_addr_cur = clr ? '0 : r_addr;

   // Tile address: advance per accepted tile, wrap once per timestep
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_addr <= '0;
      else if (w_in_fire)
         r_addr <= (w_addr_cur == LAST_ADDR) ? '0 : w_addr_cur + S_ADDR_W'(1);
      else if (clr)
         r_addr <= '0;
   end

   // Stage 1: capture operands; RAM read data lands alongside in the RAM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_stale <= 1'b0;
         r_s1_lam   <= '0;
         r_s1_xt    <= '0;
         r_s1_addr  <= '0;
      end else if (w_in_fire) begin
         r_s1_valid <= 1'b1;
         r_s1_stale <= 1'b0;
         r_s1_lam   <= in_lam_vec;
         r_s1_xt    <= in_xt_vec;
         r_s1_addr  <= w_addr_cur;
      end else if (w_s1_adv) begin
         r_s1_valid <= 1'b0;
      end else if (clr && r_s1_valid) begin
         // A tile held across clr still writes back but must not mark init
         r_s1_stale <= 1'b1;
      end
   end

   ew_state_ram #(
      .ADDR_W (S_ADDR_W),
      .WIDTH  (VEC_W)
   ) u_ram (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (clr),
      .rd_en       (w_in_fire),
      .rd_addr     (w_addr_cur),
      .rd_data     (w_ram_rd_data),
      .rd_init     (w_ram_rd_init),
      .wr_en       (w_s1_adv),
      .wr_set_init (!r_s1_stale),
      .wr_addr     (r_s1_addr),
      .wr_data     (w_s_new)
   );

   generate
      for (genvar l = 0; l < TILE_SIZE; l++) begin : g_lane
         lam_t               w_lam;
         s_t                 w_xt;
         s_t                 w_sp;
         logic signed [34:0] w_lam35;
         logic signed [34:0] w_om35;
         logic signed [34:0] w_xt35;
         logic signed [34:0] w_sp35;
         logic signed [34:0] w_acc;

         assign w_lam   = r_s1_lam[l*DATA_WIDTH +: DATA_WIDTH];
         assign w_xt    = r_s1_xt[l*DATA_WIDTH +: DATA_WIDTH];
         assign w_sp    = w_ram_rd_init ? w_ram_rd_data[l*DATA_WIDTH +: DATA_WIDTH] : '0;
         assign w_lam35 = {19'd0, w_lam};
         assign w_om35  = 35'(ONE_Q016) - w_lam35;
         assign w_xt35  = 35'(w_xt);
         assign w_sp35  = 35'(w_sp);
         assign w_acc   = w_sp35 * w_lam35 + w_xt35 * w_om35 + 35'(ROUND_HALF);
         assign w_s_new[l*DATA_WIDTH +: DATA_WIDTH] = sat16(w_acc >>> SHIFT);
      end
   endgenerate

   // Stage 2: output register, frozen while downstream back-pressures
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_s2_last  <= 1'b0;
         r_s2_vec   <= '0;
      end else if (w_s2_free) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_vec  <= w_s_new;
            r_s2_last <= (r_s1_addr == LAST_ADDR);
         end
      end
   end

   assign s_out_valid = r_s2_valid;
   assign s_out_vec   = r_s2_vec;
   assign s_out_last  = r_s2_last;

`ifdef EW_STALL_CNT_EN
   logic [31:0] r_stall_cnt;

   // Saturating count of cycles where output is offered but not taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_stall_cnt <= '0;
      else if (clr)
         r_stall_cnt <= '0;
      else if (r_s2_valid && !s_out_ready && (r_stall_cnt != '1))
         r_stall_cnt <= r_stall_cnt + 32'd1;
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule : ew_state_update_tile
`default_nettype wire

// File: tb/tb_ew_state_update_tile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ew_state_update_tile
//  Brief    : Scoreboard bench for ew_state_update_tile; directed tiles with
//             hand-computed results, monitor pops expectations on each
//             accepted output. Honours EW_STALL_CNT_EN when defined.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ew_state_update_tile;

   localparam int VW = 64;
   localparam int NT = 64;

   typedef struct packed {
      logic [VW-1:0] vec;
      logic          last;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clr = 1'b0;
   logic          in_valid = 1'b0;
   logic          s_out_ready = 1'b1;
   logic [VW-1:0] in_lam_vec = '0;
   logic [VW-1:0] in_xt_vec = '0;
   logic          in_ready;
   logic          s_out_valid;
   logic          s_out_last;
   logic [VW-1:0] s_out_vec;
`ifdef EW_STALL_CNT_EN
   logic [31:0]   stall_cnt;
`endif

   exp_t          sb_q[$];
   exp_t          mon_e;
   int            n_err = 0;
   int            n_chk = 0;
   int            tb_addr = 0;
   bit            hold_prev = 1'b0;
   logic [VW:0]   hold_val;
   bit            ctl_seen;

   always #5 clk = ~clk;

   ew_state_update_tile dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (clr),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_lam_vec  (in_lam_vec),
      .in_xt_vec   (in_xt_vec),
      .s_out_valid (s_out_valid),
      .s_out_ready (s_out_ready),
      .s_out_vec   (s_out_vec),
      .s_out_last  (s_out_last)
`ifdef EW_STALL_CNT_EN
      ,
      .stall_cnt   (stall_cnt)
`endif
   );

   function automatic logic [VW-1:0] lanes(input int a, input int b, input int c, input int d);
      return {16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   function automatic logic [VW-1:0] rep(input int a);
      return lanes(a, a, a, a);
   endfunction

   task automatic check(input string name, input logic [VW:0] act, input logic [VW:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // Monitor: pop and compare on every accepted output; verify hold stability
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_prev = 1'b0;
      end else begin
         if (hold_prev && s_out_valid)
            check("hold_stable", {s_out_vec, s_out_last}, hold_val);
         if (s_out_valid && s_out_ready) begin
            if (sb_q.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL unexpected_output: got %h required no output", s_out_vec);
            end else begin
               mon_e = sb_q.pop_front();
               check("s_out_vec", {1'b0, s_out_vec}, {1'b0, mon_e.vec});
               check("s_out_last", {64'd0, s_out_last}, {64'd0, mon_e.last});
            end
         end
         hold_prev = s_out_valid && !s_out_ready;
         hold_val  = {s_out_vec, s_out_last};
      end
   end

   task automatic send(input logic [VW-1:0] lam, input logic [VW-1:0] xt,
                       input logic [VW-1:0] exp_vec, input bit do_clr, input bit push);
      bit fired;
      int a;
      fired = 1'b0;
      in_valid   = 1'b1;
      in_lam_vec = lam;
      in_xt_vec  = xt;
      for (int k = 0; k < 100 && !fired; k++) begin
         @(negedge clk);
         fired = in_ready;
         if (fired && do_clr)
            clr = 1'b1;
         @(posedge clk);
         #1;
         clr = 1'b0;
      end
      in_valid = 1'b0;
      if (!fired) begin
         n_chk++;
         n_err++;
         $display("FAIL send_timeout: in_ready got 0 required 1 within 100 cycles");
      end else begin
         a = do_clr ? 0 : tb_addr;
         if (push)
            sb_q.push_back(exp_t'{vec: exp_vec, last: (a == NT-1)});
         tb_addr = (a == NT-1) ? 0 : a + 1;
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 200 && sb_q.size() != 0; k++)
         @(posedge clk);
      n_chk++;
      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d outstanding required 0", sb_q.size());
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic clr_pulse();
      @(negedge clk);
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      tb_addr = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation got no finish required finish within 200us");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", {64'd0, s_out_valid}, 65'd0);
      check("rst_ready", {64'd0, in_ready}, 65'd1);
      check("rst_vec", {1'b0, s_out_vec}, 65'd0);
      check("rst_last", {64'd0, s_out_last}, 65'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      clr_pulse();

      // First tile: 0.5*0 + 0.5*1.0 = 0.5 (128), visible two cycles after fire
      send(rep(32768), rep(256), rep(128), 1'b0, 1'b1);
      check("latency_early", {64'd0, s_out_valid}, 65'd0);
      @(posedge clk);
      #1;
      check("latency_2cyc", {64'd0, s_out_valid}, 65'd1);
      for (int i = 1; i < NT; i++)
         send(rep(32768), rep(256), rep(128), 1'b0, 1'b1);
      // Second pass at addr 0: 0.5*128 + 0.5*256 = 192
      send(rep(32768), rep(256), rep(192), 1'b0, 1'b1);

      // lam=0 passes xt through; lam=0xFFFF keeps s_prev
      send(rep(0), rep(-512), rep(-512), 1'b0, 1'b1);
      send(rep(0), lanes(1000, -1000, 300, -7), lanes(1000, -1000, 300, -7), 1'b0, 1'b1);
      for (int i = 0; i < 63; i++)
         send(rep(0), rep(0), rep(0), 1'b0, 1'b1);
      send(rep(65535), rep(0), lanes(1000, -1000, 300, -7), 1'b0, 1'b1);
      drain();

      // Back-pressure for 5 cycles while streaming
      clr_pulse();
      fork
         begin
            for (int i = 0; i < 12; i++)
               send(rep(0), lanes(4*i+1, 4*i+2, 4*i+3, 4*i+4),
                    lanes(4*i+1, 4*i+2, 4*i+3, 4*i+4), 1'b0, 1'b1);
         end
         begin
            ctl_seen = 1'b0;
            for (int k = 0; k < 50 && !ctl_seen; k++) begin
               @(negedge clk);
               ctl_seen = s_out_valid;
            end
            check("stall_start", {64'd0, ctl_seen}, 65'd1);
            @(posedge clk);
            #1;
            s_out_ready = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            check("stall_in_ready", {64'd0, in_ready}, 65'd0);
            check("stall_valid", {64'd0, s_out_valid}, 65'd1);
            repeat (3) @(posedge clk);
            #1;
            s_out_ready = 1'b1;
`ifdef EW_STALL_CNT_EN
            check("stall_cnt_5", {33'd0, stall_cnt}, 65'd5);
`endif
         end
      join
      drain();

      // clr concurrent with the 11th tile: that tile goes to addr 0, s_prev=0
      clr_pulse();
      for (int i = 0; i < 10; i++)
         send(rep(32768), rep(256), rep(128), 1'b0, 1'b1);
      send(rep(16384), rep(400), rep(300), 1'b1, 1'b1);
      for (int i = 0; i < 9; i++)
         send(rep(32768), rep(256), rep(128), 1'b0, 1'b1);
      for (int i = 0; i < 54; i++)
         send(rep(0), rep(0), rep(0), 1'b0, 1'b1);
      // addr 0 now holds 300: 0.5*300 + 0 = 150
      send(rep(32768), rep(0), rep(150), 1'b0, 1'b1);
      drain();

      // Reset with two tiles in flight
      send(rep(0), rep(5), rep(5), 1'b0, 1'b0);
      send(rep(0), rep(6), rep(6), 1'b0, 1'b0);
      check("inflight_valid", {64'd0, s_out_valid}, 65'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_valid", {64'd0, s_out_valid}, 65'd0);
      check("midrst_vec", {1'b0, s_out_vec}, 65'd0);
      check("midrst_last", {64'd0, s_out_last}, 65'd0);
      check("midrst_ready", {64'd0, in_ready}, 65'd1);
`ifdef EW_STALL_CNT_EN
      check("midrst_stall_cnt", {33'd0, stall_cnt}, 65'd0);
`endif
      sb_q.delete();
      tb_addr = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      // Fresh state and addr 0: every lane 128, last on the 64th tile
      for (int i = 0; i < NT; i++)
         send(rep(32768), rep(256), rep(128), 1'b0, 1'b1);
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule : tb_ew_state_update_tile
`default_nettype wire
